branch_pc_ctrl: RTL and testbench
=================================

Name: branch_pc_ctrl

Overview:
- Program-counter and branch-resolution stage directly downstream of the flag register.
- Consumes the NVZ bus (N=bit2, V=bit1, Z=bit0, already bypassed for the current instruction) plus decoded branch fields, and decides the next PC.
- Owns the PC register, the taken-branch flush bubble, and the HLT drain/halt sequence feeding fetch and the top-level halt indication.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- HALT_DRAIN, 4, cycles after HLT before halted asserts (0..15); covers pipeline drain.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  freeze request from hazard logic.
- opcode  in  4  current instruction opcode: B=1100, BR=1101, PCS=1110, HLT=1111.
- cond  in  3  branch condition code ccc.
- imm9  in  9  signed B offset in words.
- br_target  in  16  register target for BR.
- NVZ  in  3  flags from the flag register.
- pc  out  16  current fetch PC.
- pc_plus2  out  16  pc+2, used for PCS writeback.
- taken  out  1  combinational: the current branch is taken.
- flush  out  1  registered bubble indicator for the instruction fetched after a taken branch.
- halted  out  1  processor halted.

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, state=RUN, flush=0, halted=0, drain counter=0, taken=0.
- Condition truth table, by ccc:
  - 000 NE: Z=0.
  - 001 EQ: Z=1.
  - 010 GT: Z=0 and N=0.
  - 011 LT: N=1.
  - 100 GE: Z=1 or (Z=0 and N=0).
  - 101 LE: N=1 or Z=1.
  - 110 OV: V=1.
  - 111 UN: always true.
- Targets, all 16-bit modulo 2^16 with wrap permitted and no error:
  - B: pc_plus2 + (sign-extended imm9 << 1).
  - BR: br_target. br_target bit0 is forced to 0.
  - pc_plus2: pc + 16'd2, also wrapping modulo 2^16.
- taken = state==RUN & ~stall & (opcode==B | opcode==BR) & cond_true.
- States:
  - RUN.
  - FLUSH.
  - DRAIN.
  - HALTED.
- Transitions on a non-stall cycle:
  - RUN, taken: pc<=target, next=FLUSH.
  - RUN, HLT: pc holds. If HALT_DRAIN==0, next=HALTED; otherwise counter<=HALT_DRAIN-1, next=DRAIN.
  - RUN, other opcode (including not-taken branch and PCS): pc<=pc_plus2.
  - FLUSH: flush=1 for exactly this cycle. Opcode, cond and NVZ inputs are ignored (bubble). pc<=pc_plus2, next=RUN.
  - DRAIN: pc holds. If counter==0, next=HALTED; otherwise decrement. Inputs are ignored.
  - HALTED: halted=1, pc frozen. Only reset exits.
- stall=1: pc, state and counter hold; taken=0; flush keeps its value. A HLT or branch present under stall is acted on in the first cycle stall is low.
- Back-to-back branches: the second branch arrives during FLUSH and is ignored by design.
- Reset during DRAIN or FLUSH: immediate return to reset values; no residual flush or halt.
- Latency: a branch is resolved in the same cycle as its flags; the new pc is visible one clock later.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- When defined, adds two outputs:
  - br_taken_cnt  out  16: increments when taken=1.
  - br_nt_cnt  out  16: increments when a B/BR in RUN with stall=0 is not taken.
  - Both saturate at 16'hFFFF, reset to 0, and hold while HALTED.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants OP_B, OP_BR, OP_PCS, OP_HLT.
  - ccc constants CC_NE..CC_UN.
  - NVZ bit-index constants.
  - pc_state_t enum (RUN, FLUSH, DRAIN, HALTED).
- One combinational sub-module, branch_cond (inputs cond and NVZ, output cond_true), which is reused by the ISA checker.

Test Plan:
- Reset and sequencing: reset release with RESET_PC=0, three NOPs -> pc 0,2,4,6; flush=0; halted=0.
- B taken with wrap: pc=16'h0010, B cond=001, NVZ=001, imm9=9'h1FE -> taken=1; next pc=16'h000E; flush=1 for one cycle; following pc=16'h0010.
- BR not taken: pc=16'h0020, BR cond=010, NVZ=100 -> taken=0; pc=16'h0022. Then cond=110, NVZ=010, br_target=16'h1235 -> pc=16'h1234.
- Stall interaction: branch and stall=1 for 2 cycles -> pc frozen, taken=0; on stall release, taken=1 and pc jumps.
- Halt drain: HLT at pc=16'h0040, HALT_DRAIN=4 -> pc stays 16'h0040; halted rises 5 cycles after HLT; assert rst mid-DRAIN -> pc=RESET_PC, halted=0.
- With BRANCH_STATS_EN: 3 taken and 2 not-taken branches -> br_taken_cnt=3, br_nt_cnt=2; a branch ignored in FLUSH is counted in neither.

Source files
------------

// File: rtl/branch_pc_ctrl_pkg.sv
// cpu_pkg: opcodes, condition codes, NVZ bit positions and PC-stage state type
// shared by branch_pc_ctrl, branch_cond and the ISA checker.
package cpu_pkg;
    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_BR  = 4'b1101;
    localparam logic [3:0] OP_PCS = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;
    localparam logic [2:0] CC_NE = 3'd0;
    localparam logic [2:0] CC_EQ = 3'd1;
    localparam logic [2:0] CC_GT = 3'd2;
    localparam logic [2:0] CC_LT = 3'd3;
    localparam logic [2:0] CC_GE = 3'd4;
    localparam logic [2:0] CC_LE = 3'd5;
    localparam logic [2:0] CC_OV = 3'd6;
    localparam logic [2:0] CC_UN = 3'd7;
    localparam int NVZ_N = 2;
    localparam int NVZ_V = 1;
    localparam int NVZ_Z = 0;
    typedef enum logic [1:0] {RUN, FLUSH, DRAIN, HALTED} pc_state_t;
endpackage

// File: rtl/branch_pc_ctrl_if.sv
// branch_pc_ctrl_if: decoded-branch inputs and PC/flush/halt outputs of the PC stage.
// Branch statistic counters exist only when BRANCH_STATS_EN is defined.
interface branch_pc_ctrl_if;
    logic        stall;
    logic [3:0]  opcode;
    logic [2:0]  cond;
    logic [8:0]  imm9;
    logic [15:0] br_target;
    logic [2:0]  NVZ;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        taken;
    logic        flush;
    logic        halted;
`ifdef BRANCH_STATS_EN
    logic [15:0] br_taken_cnt;
    logic [15:0] br_nt_cnt;
    modport master (output stall, opcode, cond, imm9, br_target, NVZ,
                    input pc, pc_plus2, taken, flush, halted, br_taken_cnt, br_nt_cnt);
    modport slave (input stall, opcode, cond, imm9, br_target, NVZ,
                   output pc, pc_plus2, taken, flush, halted, br_taken_cnt, br_nt_cnt);
`else
    modport master (output stall, opcode, cond, imm9, br_target, NVZ,
                    input pc, pc_plus2, taken, flush, halted);
    modport slave (input stall, opcode, cond, imm9, br_target, NVZ,
                   output pc, pc_plus2, taken, flush, halted);
`endif
endinterface

// File: rtl/branch_pc_ctrl_cond.sv
// branch_cond: evaluates condition code ccc against the NVZ flags.
import cpu_pkg::*;
module branch_cond (
    input  logic [2:0] cond,
    input  logic [2:0] NVZ,
    output logic       cond_true
);
    logic n, v, z;
    assign n = NVZ[NVZ_N];
    assign v = NVZ[NVZ_V];
    assign z = NVZ[NVZ_Z];
    always_comb begin
        cond_true = 1'b1;
        case (cond)
            CC_NE: cond_true = ~z;
            CC_EQ: cond_true = z;
            CC_GT: cond_true = ~z & ~n;
            CC_LT: cond_true = n;
            CC_GE: cond_true = z | ~n;
            CC_LE: cond_true = n | z;
            CC_OV: cond_true = v;
            CC_UN: cond_true = 1'b1;
        endcase
    end
endmodule

// File: rtl/branch_pc_ctrl.sv
// branch_pc_ctrl: PC register, branch resolution, taken-branch bubble and HLT drain.
// Define BRANCH_STATS_EN to add saturating taken/not-taken branch counters.
import cpu_pkg::*;
module branch_pc_ctrl #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          HALT_DRAIN = 4
) (
    input logic         clk,
    input logic         rst,
    branch_pc_ctrl_if.slave bus
);
    localparam logic [3:0] DRAIN_INIT = 4'(HALT_DRAIN > 0 ? HALT_DRAIN - 1 : 0);
    pc_state_t   state, state_nx;
    logic [15:0] pc, pc_nx, pc_plus2, target;
    logic [3:0]  cnt, cnt_nx;
    logic        cond_true, is_br, live, taken;
    branch_cond u_cond (.cond(bus.cond), .NVZ(bus.NVZ), .cond_true(cond_true));
    assign pc_plus2 = pc + 16'd2;
    assign is_br    = bus.opcode == OP_B || bus.opcode == OP_BR;
    assign target   = bus.opcode == OP_BR ? bus.br_target & 16'hFFFE
                                          : pc_plus2 + {{6{bus.imm9[8]}}, bus.imm9, 1'b0};
    // a branch only counts when it is actually being decided this cycle
    assign live  = rst && state == RUN && !bus.stall && is_br;
    assign taken = live && cond_true;
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        cnt_nx   = cnt;
        if (!bus.stall) begin
            case (state)
                RUN: begin
                    if (taken) begin
                        pc_nx    = target;
                        state_nx = FLUSH;
                    end else if (bus.opcode == OP_HLT) begin
                        state_nx = HALT_DRAIN == 0 ? HALTED : DRAIN;
                        cnt_nx   = DRAIN_INIT;
                    end else begin
                        pc_nx = pc_plus2;
                    end
                end
                FLUSH: begin
                    pc_nx    = pc_plus2;
                    state_nx = RUN;
                end
                DRAIN: begin
                    state_nx = cnt == 4'd0 ? HALTED : DRAIN;
                    cnt_nx   = cnt == 4'd0 ? cnt : cnt - 4'd1;
                end
                HALTED: state_nx = HALTED;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            pc    <= RESET_PC;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            cnt   <= cnt_nx;
        end
    end
    assign bus.pc       = pc;
    assign bus.pc_plus2 = pc_plus2;
    assign bus.taken    = taken;
    assign bus.flush    = state == FLUSH;
    assign bus.halted   = state == HALTED;
`ifdef BRANCH_STATS_EN
    logic [15:0] tk_cnt, nt_cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tk_cnt <= 16'd0;
            nt_cnt <= 16'd0;
        end else begin
            if (taken && tk_cnt != 16'hFFFF) tk_cnt <= tk_cnt + 16'd1;
            if (live && !cond_true && nt_cnt != 16'hFFFF) nt_cnt <= nt_cnt + 16'd1;
        end
    end
    assign bus.br_taken_cnt = tk_cnt;
    assign bus.br_nt_cnt    = nt_cnt;
`endif
endmodule

// File: tb/tb_branch_pc_ctrl.sv
// tb_branch_pc_ctrl: directed vectors for branch_pc_ctrl with a per-cycle reference model
// and hand-computed literal checks; builds with or without BRANCH_STATS_EN.
module tb_branch_pc_ctrl;
    import cpu_pkg::*;
    localparam logic [15:0] RPC = 16'h0000;
    localparam int          HD  = 4;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    branch_pc_ctrl_if bus();
    branch_pc_ctrl #(.RESET_PC(RPC), .HALT_DRAIN(HD)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    // reference model: pc, pending bubble, edges elapsed since HLT, branch tallies
    logic [15:0] m_pc  = RPC;
    bit          m_bub = 1'b0;
    int          m_hlt = 0;
    int          m_tk  = 0;
    int          m_nt  = 0;
    logic [15:0] m_tgt, e_pp;

    function automatic bit cc(input logic [2:0] c, input logic [2:0] f);
        bit n = f[2];
        bit v = f[1];
        bit z = f[0];
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic bit m_isbr();
        return bus.opcode == OP_B || bus.opcode == OP_BR;
    endfunction

    function automatic bit m_taken();
        return rst && !m_bub && m_hlt == 0 && !bus.stall && m_isbr() && cc(bus.cond, bus.NVZ);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pc = RPC; m_bub = 1'b0; m_hlt = 0; m_tk = 0; m_nt = 0;
        end else if (!bus.stall) begin
            if (m_hlt > 0) begin
                if (m_hlt <= HD) m_hlt++;
            end else if (m_bub) begin
                m_pc += 16'd2; m_bub = 1'b0;
            end else if (m_isbr()) begin
                if (cc(bus.cond, bus.NVZ)) begin
                    if (bus.opcode == OP_BR) m_tgt = bus.br_target & 16'hFFFE;
                    else m_tgt = m_pc + 16'd2 + 16'(2 * (bus.imm9[8] ? int'(bus.imm9) - 512 : int'(bus.imm9)));
                    m_pc = m_tgt; m_bub = 1'b1;
                    if (m_tk < 65535) m_tk++;
                end else begin
                    m_pc += 16'd2;
                    if (m_nt < 65535) m_nt++;
                end
            end else if (bus.opcode == OP_HLT) begin
                m_hlt = 1;
            end else begin
                m_pc += 16'd2;
            end
        end
    end

    always @(negedge clk) begin
        e_pp = m_pc + 16'd2;
        check("pc", bus.pc, m_pc);
        check("pc_plus2", bus.pc_plus2, e_pp);
        check("taken", bus.taken, m_taken());
        check("flush", bus.flush, m_bub);
        check("halted", bus.halted, m_hlt > HD);
`ifdef BRANCH_STATS_EN
        check("br_taken_cnt", bus.br_taken_cnt, m_tk);
        check("br_nt_cnt", bus.br_nt_cnt, m_nt);
`endif
    end

    task automatic step(input logic [3:0] op, input logic [2:0] c, input logic [8:0] im,
                        input logic [15:0] tg, input logic [2:0] f, input logic st, input int exp_tk);
        bus.opcode = op; bus.cond = c; bus.imm9 = im; bus.br_target = tg; bus.NVZ = f; bus.stall = st;
        #1;
        if (exp_tk >= 0) check("taken_lit", bus.taken, exp_tk);
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        step(4'h0, 3'd0, 9'd0, 16'd0, 3'd0, 1'b0, -1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_pc", bus.pc, RPC);
        check("rst_flush", bus.flush, 0);
        check("rst_halted", bus.halted, 0);
        check("rst_taken", bus.taken, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        bus.opcode = OP_B; bus.cond = CC_UN; bus.imm9 = 9'd0; bus.br_target = 16'd0;
        bus.NVZ = 3'd0; bus.stall = 1'b0;
        #3;
        check("rst_pc", bus.pc, 16'h0000);
        check("rst_pp", bus.pc_plus2, 16'h0002);
        check("rst_taken", bus.taken, 0);
        check("rst_flush", bus.flush, 0);
        check("rst_halted", bus.halted, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        nop(); check("seq_pc2", bus.pc, 16'h0002);
        nop(); check("seq_pc4", bus.pc, 16'h0004);
        nop(); check("seq_pc6", bus.pc, 16'h0006);
        check("seq_flush", bus.flush, 0);
        // B taken with negative offset
        step(OP_BR, CC_UN, 9'd0, 16'h000E, 3'b000, 1'b0, 1);
        check("br_pc", bus.pc, 16'h000E);
        check("br_flush", bus.flush, 1);
        nop(); check("pc_10", bus.pc, 16'h0010);
        check("flush_drop", bus.flush, 0);
        step(OP_B, CC_EQ, 9'h1FE, 16'd0, 3'b001, 1'b0, 1);
        check("b_neg_pc", bus.pc, 16'h000E);
        check("b_flush", bus.flush, 1);
        nop(); check("b_after", bus.pc, 16'h0010);
        // BR not taken then taken with odd target
        step(OP_BR, CC_UN, 9'd0, 16'h001E, 3'b000, 1'b0, 1);
        nop(); check("pc_20", bus.pc, 16'h0020);
        step(OP_BR, CC_GT, 9'd0, 16'h5555, 3'b100, 1'b0, 0);
        check("br_nt_pc", bus.pc, 16'h0022);
        step(OP_BR, CC_OV, 9'd0, 16'h1235, 3'b010, 1'b0, 1);
        check("br_odd_pc", bus.pc, 16'h1234);
        nop(); check("pc_1236", bus.pc, 16'h1236);
        // back-to-back: second branch lands in the bubble
        step(OP_B, CC_UN, 9'd4, 16'd0, 3'b000, 1'b0, 1);
        check("b2b_pc", bus.pc, 16'h1240);
        step(OP_B, CC_UN, 9'd4, 16'd0, 3'b000, 1'b0, 0);
        check("b2b_ign", bus.pc, 16'h1242);
        check("b2b_flush", bus.flush, 0);
        // stall holds branch until release
        step(OP_B, CC_UN, 9'd0, 16'd0, 3'b000, 1'b1, 0);
        check("stall_pc1", bus.pc, 16'h1242);
        step(OP_B, CC_UN, 9'd0, 16'd0, 3'b000, 1'b1, 0);
        check("stall_pc2", bus.pc, 16'h1242);
        step(OP_B, CC_UN, 9'd0, 16'd0, 3'b000, 1'b0, 1);
        check("stall_rel", bus.pc, 16'h1244);
        step(4'h0, 3'd0, 9'd0, 16'd0, 3'd0, 1'b1, 0);
        check("stall_flush", bus.flush, 1);
        check("stall_fpc", bus.pc, 16'h1244);
        nop(); check("unstall", bus.pc, 16'h1246);
        // wrap around 2^16
        step(OP_BR, CC_UN, 9'd0, 16'hFFFF, 3'b000, 1'b0, 1);
        check("wrap_pc", bus.pc, 16'hFFFE);
        check("wrap_pp", bus.pc_plus2, 16'h0000);
        nop(); check("wrap_0", bus.pc, 16'h0000);
        step(OP_B, CC_UN, 9'h1F0, 16'd0, 3'b000, 1'b0, 1);
        check("b_wrap", bus.pc, 16'hFFE2);
        nop();
`ifdef BRANCH_STATS_EN
        check("stat_tk", bus.br_taken_cnt, 8);
        check("stat_nt", bus.br_nt_cnt, 1);
`endif
        // condition spot checks, then every cond x NVZ combination
        step(OP_B, CC_GE, 9'd0, 16'd0, 3'b100, 1'b0, 0);
        step(OP_B, CC_LE, 9'd0, 16'd0, 3'b001, 1'b0, 1); nop();
        step(OP_B, CC_GT, 9'd0, 16'd0, 3'b000, 1'b0, 1); nop();
        step(OP_B, CC_NE, 9'd0, 16'd0, 3'b001, 1'b0, 0);
        step(OP_PCS, 3'd0, 9'd0, 16'd0, 3'd0, 1'b0, 0);
        for (int c = 0; c < 8; c++)
            for (int f = 0; f < 8; f++) begin
                step(OP_B, 3'(c), 9'd0, 16'd0, 3'(f), 1'b0, -1);
                if (m_bub) nop();
            end
        // halt drain
        step(OP_BR, CC_UN, 9'd0, 16'h003E, 3'b000, 1'b0, 1);
        nop(); check("pc_40", bus.pc, 16'h0040);
        step(OP_HLT, 3'd0, 9'd0, 16'd0, 3'd0, 1'b0, 0);
        check("hlt_pc", bus.pc, 16'h0040);
        check("hlt_h0", bus.halted, 0);
        for (int i = 1; i <= 6; i++) begin
            step(OP_B, CC_UN, 9'd8, 16'd0, 3'd0, 1'b0, 0);
            check("halt_pc", bus.pc, 16'h0040);
            check("halt_rise", bus.halted, i >= 4);
        end
        do_reset();
        nop(); check("post_rst", bus.pc, 16'h0002);
        step(OP_HLT, 3'd0, 9'd0, 16'd0, 3'd0, 1'b0, 0);
        nop(); nop();
        do_reset();
        for (int i = 0; i < 6; i++) nop();
        check("no_res_halt", bus.halted, 0);
        check("run_pc", bus.pc, 16'h000C);
        step(OP_BR, CC_UN, 9'd0, 16'h0100, 3'b000, 1'b0, 1);
        check("pre_rst_fl", bus.flush, 1);
        do_reset();
        nop(); check("no_res_fl", bus.flush, 0);
        check("pc_after", bus.pc, 16'h0002);
        // stall inside drain delays halt
        step(OP_HLT, 3'd0, 9'd0, 16'd0, 3'd0, 1'b0, 0);
        step(4'h0, 3'd0, 9'd0, 16'd0, 3'd0, 1'b1, 0);
        step(4'h0, 3'd0, 9'd0, 16'd0, 3'd0, 1'b1, 0);
        nop(); nop(); nop();
        check("stall_drain", bus.halted, 0);
        nop();
        check("stall_halt", bus.halted, 1);
        check("stall_hpc", bus.pc, 16'h0002);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
